// File: rtl/mux_2_entries_sync.sv
// mux_2_entries_sync: registered 4-to-1 entry selector with registered one-hot select decode
module mux_2_entries_sync #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [4*WIDTH-1:0] in,
    input  logic [1:0]         sel,
    output logic [WIDTH-1:0]   out,
    output logic [3:0]         dec,
    output logic               valid
);
    logic [WIDTH-1:0] out_q, out_d, pick;
    logic [3:0]       dec_q, dec_d, sel_oh;
    logic             valid_q, valid_d;
    // decode sel once and reuse the one-hot both as the registered decode and as the mux select
    always_comb begin
        sel_oh = 4'b0001 << sel;
        pick = '0;
        for (int k = 0; k < 4; k++)
            if (sel_oh[k]) pick = in[k*WIDTH +: WIDTH];
        out_d = en ? pick : out_q;
        dec_d = en ? sel_oh : dec_q;
        valid_d = en | valid_q;
    end
    // state update; reset wins over load
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            dec_q <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            out_q <= out_d;
            dec_q <= dec_d;
            valid_q <= valid_d;
        end
    end
    assign out = out_q;
    assign dec = dec_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_mux_2_entries_sync.sv
// tb_mux_2_entries_sync: directed checks of the registered selector/decoder at WIDTH=1 and WIDTH=8
module tb_mux_2_entries_sync;
    logic        clk = 1'b0;
    logic        rst, en;
    logic [1:0]  sel;
    logic [3:0]  in1;
    logic [31:0] in8;
    logic        out1, valid1, valid8;
    logic [7:0]  out8;
    logic [3:0]  dec1, dec8;
    int tests = 0;
    int fails = 0;
    logic        m_known = 1'b0;
    logic        m_out1, m_valid;
    logic [7:0]  m_out8;
    logic [3:0]  m_dec;
    logic [7:0]  ent8 [4];

    mux_2_entries_sync #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .in(in1), .sel(sel),
        .out(out1), .dec(dec1), .valid(valid1)
    );
    mux_2_entries_sync #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .in(in8), .sel(sel),
        .out(out8), .dec(dec8), .valid(valid8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: entries viewed as an array, selected entry copied out, decode is a set bit at position sel
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) ent8[k] = in8[8*k +: 8];
        if (rst) begin
            m_known <= 1'b1;
            m_out1 <= 1'b0;
            m_out8 <= 8'h00;
            m_dec <= 4'b0000;
            m_valid <= 1'b0;
        end else if (en) begin
            m_out1 <= in1[sel];
            m_out8 <= ent8[sel];
            m_dec <= 4'(1 << int'(sel));
            m_valid <= 1'b1;
        end
    end

    // every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (m_known) begin
            chk("model out1", {31'b0, out1}, {31'b0, m_out1});
            chk("model out8", {24'b0, out8}, {24'b0, m_out8});
            chk("model dec1", {28'b0, dec1}, {28'b0, m_dec});
            chk("model dec8", {28'b0, dec8}, {28'b0, m_dec});
            chk("model valid", {30'b0, valid1, valid8}, {30'b0, m_valid, m_valid});
        end
    end

    task automatic apply(input logic r, input logic e, input logic [1:0] s,
                         input logic [3:0] i1, input logic [31:0] i8);
        rst = r; en = e; sel = s; in1 = i1; in8 = i8;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input logic o1, input logic [7:0] o8,
                              input logic [3:0] d, input logic v);
        chk({name, " out1"}, {31'b0, out1}, {31'b0, o1});
        chk({name, " out8"}, {24'b0, out8}, {24'b0, o8});
        chk({name, " dec"}, {24'b0, dec1, dec8}, {24'b0, d, d});
        chk({name, " valid"}, {30'b0, valid1, valid8}, {30'b0, v, v});
    endtask

    localparam logic [31:0] D8 = 32'hDDCCBBAA;
    logic [7:0] exp8 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [3:0] walk [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

    initial begin
        rst = 1'b1; en = 1'b1; sel = 2'd3; in1 = 4'hF; in8 = 32'hFFFFFFFF;
        for (int c = 0; c < 2; c++) begin
            apply(1'b1, 1'b1, 2'd3, 4'hF, 32'hFFFFFFFF);
            expect_lit("reset", 1'b0, 8'h00, 4'b0000, 1'b0);
        end
        for (int s = 0; s < 4; s++) begin
            apply(1'b0, 1'b1, 2'(s), 4'h8, D8);
            expect_lit("sweep", s == 3, exp8[s], walk[s], 1'b1);
        end
        for (int s = 0; s < 4; s++) begin
            apply(1'b0, 1'b1, 2'(s), walk[s], D8);
            expect_lit("walk diag", 1'b1, exp8[s], walk[s], 1'b1);
        end
        for (int s = 0; s < 4; s++) begin
            apply(1'b0, 1'b1, 2'd0, walk[s], D8);
            expect_lit("walk sel0", s == 0, 8'hAA, 4'b0001, 1'b1);
        end
        apply(1'b0, 1'b1, 2'd3, 4'h8, D8);
        expect_lit("hold load", 1'b1, 8'hDD, 4'b1000, 1'b1);
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
            expect_lit("hold", 1'b1, 8'hDD, 4'b1000, 1'b1);
        end
        apply(1'b1, 1'b1, 2'd3, 4'hF, D8);
        expect_lit("mid reset", 1'b0, 8'h00, 4'b0000, 1'b0);
        apply(1'b0, 1'b0, 2'd1, 4'hF, D8);
        expect_lit("idle after reset", 1'b0, 8'h00, 4'b0000, 1'b0);
        apply(1'b0, 1'b1, 2'd2, 4'h4, D8);
        expect_lit("reload", 1'b1, 8'hCC, 4'b0100, 1'b1);
        for (int c = 0; c < 40; c++)
            apply(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 4'($urandom), $urandom);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
